// File: rtl/alu_reg_sequencer_if.sv
// Command channel between a command source and alu_reg_sequencer.
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
// the source may change cmd_* freely after that edge, and done/result form a one-cycle completion beat.
interface alu_reg_sequencer_if #(
  parameter int W = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [2:0]   cmd_oc;
  logic [W-1:0] cmd_imm;
  logic         cmd_fill;
  logic         done;
  logic [W-1:0] result;
  logic         busy;

  modport master (
    output cmd_valid, cmd_op, cmd_oc, cmd_imm, cmd_fill,
    input  cmd_ready, done, result, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_oc, cmd_imm, cmd_fill,
    output cmd_ready, done, result, busy
  );
endinterface

// File: rtl/alu_reg_sequencer.sv
// Command sequencer that treats an external shift/count register plus a 4-bit ALU
// as one accumulator: it strobes register controls, drives ALU operands and writes results back.
module alu_reg_sequencer #(
  parameter int W     = 4,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_reg_sequencer_if.slave   cmd,
  output logic                 reg_cl,
  output logic                 reg_ld,
  output logic                 reg_inc,
  output logic                 reg_dec,
  output logic                 reg_sr,
  output logic                 reg_ir,
  output logic                 reg_sl,
  output logic                 reg_il,
  output logic [W-1:0]         reg_in,
  input  logic [W-1:0]         reg_out,
  output logic [2:0]           alu_oc,
  output logic [W-1:0]         alu_a,
  output logic [W-1:0]         alu_b,
  input  logic [W-1:0]         alu_f,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STEP     = 3'd1,
    ALU_EVAL = 3'd2,
    ALU_WB   = 3'd3,
    REPEAT   = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_CLEAR = 3'd2;
  localparam logic [2:0] OP_ALU   = 3'd3;
  localparam logic [2:0] OP_SHL   = 3'd4;
  localparam logic [2:0] OP_SHR   = 3'd5;
  localparam logic [2:0] OP_INC   = 3'd6;
  localparam logic [2:0] OP_DEC   = 3'd7;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               fill_q, fill_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               cl_d, ld_d, inc_d, dec_d, sr_d, ir_d, sl_d, il_d;
  logic [W-1:0]       reg_in_d;
  logic [2:0]         alu_oc_d;
  logic [W-1:0]       alu_a_d, alu_b_d;
  logic               rep_on;
  logic [2:0]         rep_op;
  logic               rep_fill;
  logic               accept;
  logic [CNT_W-1:0]   imm_cnt;

  assign accept  = cmd.cmd_valid && ready_q;
  assign imm_cnt = CNT_W'(cmd.cmd_imm);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    fill_d   = fill_q;
    ready_d  = 1'b0;
    cl_d     = 1'b0;
    ld_d     = 1'b0;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    sr_d     = 1'b0;
    ir_d     = 1'b0;
    sl_d     = 1'b0;
    il_d     = 1'b0;
    reg_in_d = '0;
    alu_oc_d = '0;
    alu_a_d  = '0;
    alu_b_d  = '0;
    rep_on   = 1'b0;
    rep_op   = op_q;
    rep_fill = fill_q;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          ready_d = 1'b0;
          op_d    = cmd.cmd_op;
          fill_d  = cmd.cmd_fill;
          case (cmd.cmd_op)
            OP_NOP:   state_d = DONE;
            OP_LOAD: begin
              state_d  = STEP;
              ld_d     = 1'b1;
              reg_in_d = cmd.cmd_imm;
            end
            OP_CLEAR: begin
              state_d = STEP;
              cl_d    = 1'b1;
            end
            OP_ALU: begin
              // reg_out is snapshotted here so operand A is the value before any write-back
              state_d  = ALU_EVAL;
              alu_oc_d = cmd.cmd_oc;
              alu_a_d  = reg_out;
              alu_b_d  = cmd.cmd_imm;
            end
            default: begin
              if (imm_cnt == '0) begin
                state_d = DONE;
              end else begin
                state_d  = REPEAT;
                cnt_d    = imm_cnt;
                rep_on   = 1'b1;
                rep_op   = cmd.cmd_op;
                rep_fill = cmd.cmd_fill;
              end
            end
          endcase
        end
      end
      STEP:     state_d = DONE;
      ALU_EVAL: begin
        state_d  = ALU_WB;
        ld_d     = 1'b1;
        reg_in_d = alu_f;
      end
      ALU_WB:   state_d = DONE;
      REPEAT: begin
        // The strobe already covered this cycle; keep it up until the count is spent
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end else begin
          rep_on = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (rep_on) begin
      case (rep_op)
        OP_SHL: begin
          sl_d = 1'b1;
          il_d = rep_fill;
        end
        OP_SHR: begin
          sr_d = 1'b1;
          ir_d = rep_fill;
        end
        OP_INC:  inc_d = 1'b1;
        OP_DEC:  dec_d = 1'b1;
        default: ;
      endcase
    end

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      fill_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      reg_cl  <= 1'b0;
      reg_ld  <= 1'b0;
      reg_inc <= 1'b0;
      reg_dec <= 1'b0;
      reg_sr  <= 1'b0;
      reg_ir  <= 1'b0;
      reg_sl  <= 1'b0;
      reg_il  <= 1'b0;
      reg_in  <= '0;
      alu_oc  <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      reg_cl  <= cl_d;
      reg_ld  <= ld_d;
      reg_inc <= inc_d;
      reg_dec <= dec_d;
      reg_sr  <= sr_d;
      reg_ir  <= ir_d;
      reg_sl  <= sl_d;
      reg_il  <= il_d;
      reg_in  <= reg_in_d;
      alu_oc  <= alu_oc_d;
      alu_a   <= alu_a_d;
      alu_b   <= alu_b_d;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign cmd.done      = done_q;
  assign cmd.busy      = busy_q;
  // The register updates on the edge that enters DONE, so result gates its live output
  assign cmd.result    = done_q ? reg_out : '0;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Directed bench for alu_reg_sequencer with a behavioural register and ALU around it;
// expected values are hand-computed constants.
module tb_alu_reg_sequencer;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  logic reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
  logic [W-1:0] reg_in, reg_out, alu_a, alu_b, alu_f;
  logic [2:0] alu_oc, state_dbg;
  logic [W-1:0] reg_q;

  alu_reg_sequencer_if #(.W(W)) cmd_if ();

  alu_reg_sequencer #(.W(W), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cmd_if),
    .reg_cl    (reg_cl),
    .reg_ld    (reg_ld),
    .reg_inc   (reg_inc),
    .reg_dec   (reg_dec),
    .reg_sr    (reg_sr),
    .reg_ir    (reg_ir),
    .reg_sl    (reg_sl),
    .reg_il    (reg_il),
    .reg_in    (reg_in),
    .reg_out   (reg_out),
    .alu_oc    (alu_oc),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register model
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       reg_q <= '0;
    else if (reg_cl)  reg_q <= '0;
    else if (reg_ld)  reg_q <= reg_in;
    else if (reg_inc) reg_q <= reg_q + 4'd1;
    else if (reg_dec) reg_q <= reg_q - 4'd1;
    else if (reg_sl)  reg_q <= {reg_q[W-2:0], reg_il};
    else if (reg_sr)  reg_q <= {reg_ir, reg_q[W-1:1]};
  end
  assign reg_out = reg_q;

  // ALU model: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not a, 6 pass b, 7 a+1
  always_comb begin
    case (alu_oc)
      3'd0:    alu_f = alu_a + alu_b;
      3'd1:    alu_f = alu_a - alu_b;
      3'd2:    alu_f = alu_a & alu_b;
      3'd3:    alu_f = alu_a | alu_b;
      3'd4:    alu_f = alu_a ^ alu_b;
      3'd5:    alu_f = ~alu_a;
      3'd6:    alu_f = alu_b;
      default: alu_f = alu_a + 4'd1;
    endcase
  end

  int checks = 0;
  int failures = 0;
  int excl_err = 0;
  int dbl_done = 0;
  int done_cnt = 0;
  logic done_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // protocol monitors
  always @(negedge clk) begin
    if ($countones({reg_cl, reg_ld, reg_inc, reg_dec, reg_sl, reg_sr}) > 1) excl_err++;
    if ((reg_il && !reg_sl) || (reg_ir && !reg_sr)) excl_err++;
    if (state_dbg != 3'd2 && {alu_oc, alu_a, alu_b} != '0) excl_err++;
    if (cmd_if.done && done_prev) dbl_done++;
    if (cmd_if.done) done_cnt++;
    done_prev = cmd_if.done;
  end

  // trace of the last command
  int t_lat;
  logic t_done;
  logic [W-1:0] t_res, t_reg_in, e_a, e_b;
  logic [2:0] e_oc;
  int n_ld, n_cl, n_inc, n_dec, n_sl, n_sr, n_il, n_ir;

  task automatic send_cmd(input logic [2:0] op, input logic [2:0] oc,
                          input logic [W-1:0] imm, input logic fill);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_if.cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(n < 40), 32'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_oc    = oc;
    cmd_if.cmd_imm   = imm;
    cmd_if.cmd_fill  = fill;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'($urandom_range(0, 7));
    cmd_if.cmd_oc    = 3'($urandom_range(0, 7));
    cmd_if.cmd_imm   = 4'($urandom_range(0, 15));
    cmd_if.cmd_fill  = 1'($urandom_range(0, 1));
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [2:0] oc,
                         input logic [W-1:0] imm, input logic fill);
    n_ld = 0; n_cl = 0; n_inc = 0; n_dec = 0; n_sl = 0; n_sr = 0; n_il = 0; n_ir = 0;
    t_lat = 0; t_done = 1'b0; t_res = '0; t_reg_in = '0; e_a = '0; e_b = '0; e_oc = '0;
    send_cmd(op, oc, imm, fill);
    for (int c = 1; c <= 40 && !t_done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        e_a  = alu_a;
        e_b  = alu_b;
        e_oc = alu_oc;
      end
      n_ld  += int'(reg_ld);
      n_cl  += int'(reg_cl);
      n_inc += int'(reg_inc);
      n_dec += int'(reg_dec);
      n_sl  += int'(reg_sl);
      n_sr  += int'(reg_sr);
      n_il  += int'(reg_il);
      n_ir  += int'(reg_ir);
      if (reg_ld) t_reg_in = reg_in;
      if (cmd_if.done) begin
        t_done = 1'b1;
        t_lat  = c;
        t_res  = cmd_if.result;
      end
    end
    check("done_seen", 32'(t_done), 32'd1);
  endtask

  logic [W-1:0] alu_exp [8];
  int acc, ready_err, d0, idle_wait;
  logic acc_prev, abort_done;

  initial begin
    alu_exp = '{4'b1000, 4'b1110, 4'b0001, 4'b0111, 4'b0110, 4'b1100, 4'b0101, 4'b0100};
    rst_n = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op = '0;
    cmd_if.cmd_oc = '0;
    cmd_if.cmd_imm = '0;
    cmd_if.cmd_fill = 1'b0;

    // reset
    repeat (2) @(negedge clk);
    check("rst_outputs", 32'({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il,
                              reg_in, alu_oc, alu_a, alu_b, cmd_if.done, cmd_if.result,
                              cmd_if.busy, cmd_if.cmd_ready}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(cmd_if.cmd_ready), 32'd0);
    @(negedge clk);
    check("ready_after_edge", 32'(cmd_if.cmd_ready), 32'd1);
    check("state_idle", 32'(state_dbg), 32'd0);

    // LOAD
    run_cmd(3'd1, 3'd0, 4'b1010, 1'b0);
    check("load_ld_cycles", n_ld, 1);
    check("load_reg_in", 32'(t_reg_in), 32'b1010);
    check("load_latency", t_lat, 2);
    check("load_result", 32'(t_res), 32'b1010);

    // NOP
    run_cmd(3'd0, 3'd0, 4'b0000, 1'b0);
    check("nop_latency", t_lat, 1);
    check("nop_strobes", n_ld + n_cl + n_inc + n_dec + n_sl + n_sr, 0);
    check("nop_result", 32'(t_res), 32'b1010);

    // CLEAR
    run_cmd(3'd2, 3'd0, 4'b0110, 1'b0);
    check("clear_cl_cycles", n_cl, 1);
    check("clear_latency", t_lat, 2);
    check("clear_result", 32'(t_res), 32'd0);

    // ALU sweep
    for (int oc = 0; oc < 8; oc++) begin
      run_cmd(3'd1, 3'd0, 4'b0011, 1'b0);
      run_cmd(3'd3, 3'(oc), 4'b0101, 1'b0);
      check($sformatf("alu%0d_a", oc), 32'(e_a), 32'b0011);
      check($sformatf("alu%0d_b", oc), 32'(e_b), 32'b0101);
      check($sformatf("alu%0d_oc", oc), 32'(e_oc), 32'(oc));
      check($sformatf("alu%0d_wb", oc), 32'(t_reg_in), 32'(alu_exp[oc]));
      check($sformatf("alu%0d_ld", oc), n_ld, 1);
      check($sformatf("alu%0d_lat", oc), t_lat, 3);
      check($sformatf("alu%0d_result", oc), 32'(t_res), 32'(alu_exp[oc]));
    end

    // INC wrap and N=0
    run_cmd(3'd1, 3'd0, 4'b1111, 1'b0);
    run_cmd(3'd6, 3'd0, 4'd3, 1'b0);
    check("inc3_cycles", n_inc, 3);
    check("inc3_latency", t_lat, 4);
    check("inc3_result", 32'(t_res), 32'b0010);
    run_cmd(3'd1, 3'd0, 4'b1111, 1'b0);
    run_cmd(3'd6, 3'd0, 4'd0, 1'b0);
    check("inc0_cycles", n_inc, 0);
    check("inc0_latency", t_lat, 1);
    check("inc0_result", 32'(t_res), 32'b1111);

    // DEC wrap
    run_cmd(3'd1, 3'd0, 4'b0001, 1'b0);
    run_cmd(3'd7, 3'd0, 4'd2, 1'b0);
    check("dec2_cycles", n_dec, 2);
    check("dec2_result", 32'(t_res), 32'b1111);

    // shifts with fill
    run_cmd(3'd1, 3'd0, 4'b0001, 1'b0);
    run_cmd(3'd4, 3'd0, 4'd2, 1'b1);
    check("shl_sl_cycles", n_sl, 2);
    check("shl_il_cycles", n_il, 2);
    check("shl_latency", t_lat, 3);
    check("shl_result", 32'(t_res), 32'b0111);
    run_cmd(3'd5, 3'd0, 4'd1, 1'b0);
    check("shr_sr_cycles", n_sr, 1);
    check("shr_ir_cycles", n_ir, 0);
    check("shr_result", 32'(t_res), 32'b0011);

    // reset during REPEAT aborts without done
    run_cmd(3'd1, 3'd0, 4'b0101, 1'b0);
    send_cmd(3'd7, 3'd0, 4'd10, 1'b0);
    check("busy_after_accept", 32'(cmd_if.busy), 32'd1);
    repeat (3) @(negedge clk);
    check("dec_mid_strobe", 32'(reg_dec), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl,
                               cmd_if.done, cmd_if.busy, cmd_if.cmd_ready}), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    abort_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (cmd_if.done) abort_done = 1'b1;
    end
    check("abort_no_done", 32'(abort_done), 32'd0);
    run_cmd(3'd1, 3'd0, 4'b0110, 1'b0);
    check("post_abort_load", 32'(t_res), 32'b0110);

    // held cmd_valid with random commands
    @(negedge clk);
    #2;
    d0 = done_cnt;
    acc = 0;
    ready_err = 0;
    acc_prev = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = 3'($urandom_range(0, 7));
      cmd_if.cmd_oc    = 3'($urandom_range(0, 7));
      cmd_if.cmd_imm   = 4'($urandom_range(0, 15));
      cmd_if.cmd_fill  = 1'($urandom_range(0, 1));
      #1;
      if (acc_prev && cmd_if.cmd_ready) ready_err++;
      acc_prev = cmd_if.cmd_ready;
      if (cmd_if.cmd_ready) acc++;
    end
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    idle_wait = 0;
    while ((cmd_if.busy || state_dbg != 3'd0) && idle_wait < 40) begin
      @(negedge clk);
      idle_wait++;
    end
    check("rand_idle_reached", 32'(idle_wait < 40), 32'd1);
    check("rand_accepts_min", 32'(acc > 10), 32'd1);
    check("rand_accepts_done", done_cnt - d0, acc);
    check("rand_ready_drop", ready_err, 0);

    check("strobe_exclusive", excl_err, 0);
    check("done_single_cycle", dbl_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_reg_sequencer.md
Name: alu_reg_sequencer

Overview:
Command-driven controller sequencing the 4-bit alu and the shift/count register as one accumulator datapath. Accepts one command at a time over a valid/ready handshake. Drives the register control strobes and the ALU opcode/operands. Writes ALU results back into the register and reports completion with a one-cycle done pulse carrying the final register value.

Parameters:
W, 4, data width of register, ALU operands and immediate
CNT_W, 4, width of repeat counter (max repeat = 2**CNT_W-1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  0 NOP, 1 LOAD, 2 CLEAR, 3 ALU, 4 SHL, 5 SHR, 6 INC, 7 DEC
cmd_oc  input  3  ALU opcode (ALU only)
cmd_imm  input  W  LOAD value / ALU b operand / repeat count (SHL..DEC)
cmd_fill  input  1  serial fill bit for shifts
reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il  output  1 each  register controls
reg_in  output  W  register parallel load data
reg_out  input  W  register contents
alu_oc  output  3  ALU opcode
alu_a, alu_b  output  W  ALU operands
alu_f  input  W  ALU result
done  output  1  one-cycle completion pulse
result  output  W  reg_out sampled in DONE; valid while done=1
busy  output  1  high from accept until done cycle inclusive

Behaviour:
- Clock/reset: single clock clk; reset rst_n asynchronous, active-low.
- All outputs registered. On reset, all outputs 0 immediately, including cmd_ready. State is IDLE and the counter is 0.
- cmd_ready rises at the first clk edge after rst_n deasserts. Reset mid-command aborts it with no done pulse.
- Handshake: accept on an edge with cmd_valid && cmd_ready. cmd_ready is 1 only in IDLE and drops for the cycle after accept. cmd_* fields are captured at accept. The source may change them freely afterwards.
- Exclusivity: at most one of cl/ld/inc/dec/sl/sr is high in any cycle. reg_il/reg_ir equal the captured fill only while reg_sl/reg_sr is high, else 0.
- alu_oc/alu_a/alu_b are 0 outside ALU_EVAL.
- States: IDLE, STEP, ALU_EVAL, ALU_WB, REPEAT, DONE.
- NOP: IDLE -> DONE. No strobes.
- LOAD: IDLE -> STEP with reg_ld=1 and reg_in=imm for one cycle, then DONE.
- CLEAR: IDLE -> STEP with reg_cl=1 for one cycle, then DONE.
- ALU: at accept, snapshot reg_out into operand A.
  - ALU_EVAL, one cycle: alu_oc=cmd_oc, alu_a=snapshot, alu_b=imm.
  - At the ALU_EVAL exit edge, capture alu_f into reg_in and go to ALU_WB.
  - ALU_WB, one cycle: reg_ld=1. Then DONE.
- SHL/SHR/INC/DEC with count N=imm:
  - N=0: IDLE -> DONE, no strobe.
  - Otherwise REPEAT asserts the op strobe for exactly N consecutive cycles. The counter loads N at accept and decrements each REPEAT edge. Exit to DONE when the counter reaches 1.
  - INC/DEC wrap modulo 2**W in the register. The sequencer does not saturate.
- DONE, one cycle: done=1, result=reg_out (already reflects the last strobe), all strobes 0. Then IDLE with cmd_ready=1.
- Accept-to-done latency: NOP 1 cycle; LOAD/CLEAR 2; ALU 3; repeat ops N+1 (1 if N=0). Back-to-back throughput adds one cycle for the return to IDLE.
- cmd_valid while busy is ignored and not queued.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then release -> all outputs 0 during reset; cmd_ready=1 one edge after release; no strobes.
- LOAD 4'b1010 -> reg_ld high for exactly 1 cycle with reg_in=1010; done 2 cycles after accept with result=1010.
- LOAD 0011 then ALU oc=cmd_oc, imm=0101 -> alu_a=0011, alu_b=0101 during ALU_EVAL; reg_ld with reg_in=alu_f one cycle later; result equals the ALU reference model value; sweep all 8 opcodes.
- LOAD 1111, INC N=3 -> reg_inc high for 3 consecutive cycles; result=0010 (wrap); INC N=0 -> done 1 cycle after accept, no strobe, result=1111.
- LOAD 0001, SHL N=2 fill=1 -> reg_sl and reg_il high for 2 cycles, result=0111; SHR N=1 fill=0 -> reg_sr=1, reg_ir=0, result=0011.
- Reset asserted during REPEAT of DEC N=10 -> strobes drop to 0 asynchronously; no done pulse; a new LOAD is accepted after release. Random commands with held cmd_valid -> at most one accept per IDLE visit and the strobe-exclusivity assertion never fires.
